// File: rtl/register_pipeline_pkg.sv
// Shared constants and helpers for the elastic register pipeline.
// Holds the default geometry, the count-width helper and the test timing constants.
package register_pipeline_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_DEPTH     = 4;
  localparam int unsigned RESET_CYCLES  = 2;
  localparam int unsigned CLK_PERIOD_NS = 50;

  // Bits needed to hold an occupancy value in the range 0..depth.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/elastic_register_pipeline_pipe_stage.sv
// One WIDTH-bit elastic register stage.
// The stage loads when it is empty or when the stage downstream can take its word.
module pipe_stage
  import register_pipeline_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  input  logic             dn_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             rdy
);

  assign rdy = !valid || dn_ready;

  // Flush drops the valid bit but leaves the data register alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (rdy) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/elastic_register_pipeline.sv
// DEPTH-stage valid/ready register pipeline with synchronous flush and occupancy count.
// Stage 0 faces the producer, and stage DEPTH-1 drives the consumer-side outputs.
module elastic_register_pipeline
  import register_pipeline_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_WIDTH,
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic accept;
  logic consume;

  // Each stage keeps its own handshake nets so that the ready chain never loops through one shared vector.
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic             v;
    logic [WIDTH-1:0] d;
    logic             rdy;
    logic             up_v;
    logic [WIDTH-1:0] up_d;
    logic             dn_rdy;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_d = in_data;
    end else begin : g_body
      assign up_v = g_stage[i-1].v;
      assign up_d = g_stage[i-1].d;
    end

    if (i == int'(DEPTH) - 1) begin : g_tail
      assign dn_rdy = out_ready;
    end else begin : g_inner
      assign dn_rdy = g_stage[i+1].rdy;
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .up_valid (up_v),
      .up_data  (up_d),
      .dn_ready (dn_rdy),
      .valid    (v),
      .data     (d),
      .rdy      (rdy)
    );
  end

  assign in_ready  = g_stage[0].rdy && !flush && !reset;
  assign out_valid = g_stage[DEPTH-1].v;
  assign out_data  = g_stage[DEPTH-1].d;

  assign accept  = in_valid && in_ready;
  assign consume = out_valid && out_ready;

  // Occupancy stays within 0..DEPTH because acceptance is gated by the ready chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(accept) - CNT_W'(consume);
    end
  end

endmodule

// File: tb/tb_elastic_register_pipeline.sv
// Directed bench for elastic_register_pipeline (WIDTH=16, DEPTH=4).
// Inputs change on negedge clk; registered outputs are sampled on the following negedge.
module tb_elastic_register_pipeline;
  import register_pipeline_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] count;

  int vectors     = 0;
  int miscompares = 0;

  elastic_register_pipeline #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #(CLK_PERIOD_NS / 2) clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  initial begin
    #(CLK_PERIOD_NS * 2000);
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    int exp_cnt;
    bit prev_ov;
    bit ov;

    // 1: reset with a live producer
    reset     = 1'b1;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'hFFFF);
    #1 chk("rst_in_ready", 32'(in_ready), 32'd0);
    for (int c = 0; c < int'(RESET_CYCLES); c++) begin
      step;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
    end
    reset = 1'b0;
    drive(1'b0, 16'h0000);
    #1 chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 5; c++) begin
      step;
      chk("rst_no_ghost", 32'(out_valid), 32'd0);
    end

    // 2: continuous stream 1..16 with out_ready=1
    exp_cnt = 0;
    prev_ov = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      drive(k <= 16, 16'(k));
      step;
      ov      = (k >= 4) && (k <= 19);
      exp_cnt = exp_cnt + ((k <= 16) ? 1 : 0) - (prev_ov ? 1 : 0);
      chk("stream_valid", 32'(out_valid), 32'(ov));
      if (ov) chk("stream_data", 32'(out_data), 32'(k - 3));
      chk("stream_count", 32'(count), 32'(exp_cnt));
      prev_ov = ov;
    end
    drive(1'b0, 16'h0000);

    // 3: fill under backpressure, then drain
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 16'(16'hA0 + j));
      #1 chk("bp_in_ready", 32'(in_ready), 32'd1);
      step;
    end
    drive(1'b1, 16'h00A4);
    #1 chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_valid", 32'(out_valid), 32'd1);
    chk("full_data", 32'(out_data), 32'h00A0);
    step;
    chk("full_hold_ready", 32'(in_ready), 32'd0);
    chk("full_hold_data", 32'(out_data), 32'h00A0);
    chk("full_hold_count", 32'(count), 32'd4);
    out_ready = 1'b1;
    #1 chk("full_pass_ready", 32'(in_ready), 32'd1);
    step;
    chk("drain_a1", 32'(out_data), 32'h00A1);
    chk("drain_cnt", 32'(count), 32'd4);
    drive(1'b1, 16'h00A5);
    step;
    chk("drain_a2", 32'(out_data), 32'h00A2);
    drive(1'b0, 16'h0000);
    for (int e = 3; e <= 5; e++) begin
      step;
      chk("drain_valid", 32'(out_valid), 32'd1);
      chk("drain_data", 32'(out_data), 32'(16'hA0 + e));
    end
    step;
    chk("drain_empty", 32'(out_valid), 32'd0);
    chk("drain_count", 32'(count), 32'd0);

    // 4: bubble collapse under backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0055);
    step;
    drive(1'b0, 16'h0000);
    #1 chk("bub_ready1", 32'(in_ready), 32'd1);
    step;
    #1 chk("bub_ready2", 32'(in_ready), 32'd1);
    step;
    drive(1'b1, 16'h00AA);
    #1 chk("bub_ready3", 32'(in_ready), 32'd1);
    step;
    drive(1'b0, 16'h0000);
    step;
    step;
    chk("bub_count", 32'(count), 32'd2);
    chk("bub_valid", 32'(out_valid), 32'd1);
    chk("bub_head", 32'(out_data), 32'h0055);
    chk("bub_ready4", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    step;
    chk("bub_next_valid", 32'(out_valid), 32'd1);
    chk("bub_next", 32'(out_data), 32'h00AA);
    step;
    chk("bub_empty", 32'(out_valid), 32'd0);
    chk("bub_end_count", 32'(count), 32'd0);

    // 5: flush with three words in flight
    for (int j = 1; j <= 3; j++) begin
      drive(1'b1, 16'(16'hB0 + j));
      step;
    end
    chk("pre_flush_count", 32'(count), 32'd3);
    flush = 1'b1;
    drive(1'b1, 16'h00EE);
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    step;
    flush = 1'b0;
    drive(1'b0, 16'h0000);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_count", 32'(count), 32'd0);
    drive(1'b1, 16'h00C1);
    step;
    drive(1'b0, 16'h0000);
    chk("post_flush_lat", 32'(out_valid), 32'd0);
    for (int c = 0; c < 2; c++) begin
      step;
      chk("post_flush_lat", 32'(out_valid), 32'd0);
    end
    step;
    chk("post_flush_valid", 32'(out_valid), 32'd1);
    chk("post_flush_data", 32'(out_data), 32'h00C1);
    step;
    chk("post_flush_empty", 32'(out_valid), 32'd0);
    chk("post_flush_count", 32'(count), 32'd0);

    // 6: reset a full stalled pipeline
    out_ready = 1'b0;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 16'(16'hD0 + j));
      step;
    end
    chk("pre_rst_count", 32'(count), 32'd4);
    chk("pre_rst_data", 32'(out_data), 32'h00D0);
    reset = 1'b1;
    drive(1'b1, 16'h0077);
    step;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_data", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    reset = 1'b0;
    drive(1'b0, 16'h0000);
    #1 chk("mid_rst_ready", 32'(in_ready), 32'd1);
    step;
    chk("post_rst_valid", 32'(out_valid), 32'd0);
    chk("post_rst_data", 32'(out_data), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
